// File: rtl/fpu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : fpu_pkg                                                       |
// | Description : Shared FPU constants, format widths and sequencer states      |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
package fpu_pkg;

  localparam int BIAS_D = 1023;
  localparam int BIAS_S = 127;
  localparam int MANT_D = 52;
  localparam int EXP_D  = 11;
  localparam int MANT_S = 23;
  localparam int EXP_S  = 8;

  localparam logic [31:0] c_nan_box = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_NORM  = 2'd1,
    ST_ROUND = 2'd2,
    ST_DONE  = 2'd3
  } cvt_state_e;

endpackage : fpu_pkg
`default_nettype wire

// File: rtl/fcvt_round.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fcvt_round                                                    |
// | Description : Round-to-nearest-even packer for a normalized magnitude       |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module fcvt_round #(
  parameter int BIAS_D = fpu_pkg::BIAS_D,
  parameter int BIAS_S = fpu_pkg::BIAS_S
) (
  input  logic [63:0] mag,
  input  logic [5:0]  shcnt,
  input  logic        sign,
  input  logic        dbl,
  output logic [63:0] result,
  output logic        nx
);
  import fpu_pkg::*;

  logic [10:0]        w_exp_base;
  logic               w_zero;

  logic [MANT_D-1:0]  w_m_d;
  logic               w_g_d;
  logic               w_st_d;
  logic               w_up_d;
  logic [MANT_D:0]    w_sum_d;
  logic [EXP_D-1:0]   w_exp_d;

  logic [MANT_S-1:0]  w_m_s;
  logic               w_g_s;
  logic               w_st_s;
  logic               w_up_s;
  logic [MANT_S:0]    w_sum_s;
  logic [EXP_S-1:0]   w_exp_s;

  // A normalized non-zero magnitude always has its MSB set.
  assign w_zero     = ~mag[63];
  assign w_exp_base = 11'd63 - {5'd0, shcnt};

  assign w_m_d   = mag[62:11];
  assign w_g_d   = mag[10];
  assign w_st_d  = |mag[9:0];
  assign w_up_d  = w_g_d & (w_st_d | w_m_d[0]);
  assign w_sum_d = {1'b0, w_m_d} + {{MANT_D{1'b0}}, w_up_d};
  // On mantissa carry-out the low field is already all zeros.
  assign w_exp_d = w_exp_base + 11'(BIAS_D) + {10'd0, w_sum_d[MANT_D]};

  assign w_m_s   = mag[62:40];
  assign w_g_s   = mag[39];
  assign w_st_s  = |mag[38:0];
  assign w_up_s  = w_g_s & (w_st_s | w_m_s[0]);
  assign w_sum_s = {1'b0, w_m_s} + {{MANT_S{1'b0}}, w_up_s};
  assign w_exp_s = w_exp_base[7:0] + 8'(BIAS_S) + {7'd0, w_sum_s[MANT_S]};

  always_comb begin
    result = 64'd0;
    nx     = 1'b0;
    if (w_zero) begin
      result = dbl ? 64'd0 : {c_nan_box, 32'd0};
    end else if (dbl) begin
      result = {sign, w_exp_d, w_sum_d[MANT_D-1:0]};
      nx     = w_g_d | w_st_d;
    end else begin
      result = {c_nan_box, sign, w_exp_s, w_sum_s[MANT_S-1:0]};
      nx     = w_g_s | w_st_s;
    end
  end

endmodule : fcvt_round
`default_nettype wire

// File: rtl/fcvt_int2fp_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fcvt_int2fp_seq                                               |
// | Description : Multi-cycle integer to single/double converter sequencer      |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module fcvt_int2fp_seq #(
  parameter int BUS_WIDTH = 64,
  parameter int BIAS_D    = fpu_pkg::BIAS_D,
  parameter int BIAS_S    = fpu_pkg::BIAS_S
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [BUS_WIDTH-1:0] req_op,
  input  logic                 req_word,
  input  logic                 req_signed,
  input  logic                 req_dbl,
  input  logic                 kill,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [BUS_WIDTH-1:0] resp_data,
  output logic                 resp_nx
);
  import fpu_pkg::*;

  cvt_state_e  r_state;
  cvt_state_e  w_state_nxt;

  logic [63:0] r_mag;
  logic [5:0]  r_shcnt;
  logic        r_sign;
  logic        r_dbl;
  logic [63:0] r_resp_data;
  logic        r_resp_nx;

  logic [63:0] w_ext;
  logic        w_sign;
  logic [63:0] w_mag_in;
  logic        w_load;
  logic        w_sh8;
  logic        w_sh1;
  logic        w_cap;
  logic [63:0] w_rnd_result;
  logic        w_rnd_nx;

  assign w_ext = req_word ? (req_signed ? {{32{req_op[31]}}, req_op[31:0]}
                                        : {32'd0, req_op[31:0]})
                          : req_op;
  assign w_sign   = req_signed & w_ext[63];
  assign w_mag_in = w_sign ? (~w_ext + 64'd1) : w_ext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_sh8       = 1'b0;
    w_sh1       = 1'b0;
    w_cap       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          w_load      = 1'b1;
          w_state_nxt = (w_mag_in == 64'd0) ? ST_ROUND : ST_NORM;
        end
      end
      ST_NORM: begin
        if (r_mag[63:56] == 8'd0) begin
          w_sh8 = 1'b1;
        end else if (!r_mag[63]) begin
          w_sh1 = 1'b1;
        end else begin
          w_state_nxt = ST_ROUND;
        end
      end
      ST_ROUND: begin
        w_cap       = 1'b1;
        w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        if (resp_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    // A flush overrides everything, including a request offered this cycle.
    if (kill) begin
      w_state_nxt = ST_IDLE;
      w_load      = 1'b0;
      w_sh8       = 1'b0;
      w_sh1       = 1'b0;
      w_cap       = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mag       <= 64'd0;
      r_shcnt     <= 6'd0;
      r_sign      <= 1'b0;
      r_dbl       <= 1'b0;
      r_resp_data <= 64'd0;
      r_resp_nx   <= 1'b0;
    end else begin
      if (w_load) begin
        r_mag   <= w_mag_in;
        r_shcnt <= 6'd0;
        r_sign  <= w_sign;
        r_dbl   <= req_dbl;
      end else if (w_sh8) begin
        r_mag   <= {r_mag[55:0], 8'd0};
        r_shcnt <= r_shcnt + 6'd8;
      end else if (w_sh1) begin
        r_mag   <= {r_mag[62:0], 1'b0};
        r_shcnt <= r_shcnt + 6'd1;
      end
      if (w_cap) begin
        r_resp_data <= w_rnd_result;
        r_resp_nx   <= w_rnd_nx;
      end
    end
  end

  fcvt_round #(
    .BIAS_D (BIAS_D),
    .BIAS_S (BIAS_S)
  ) u_round (
    .mag    (r_mag),
    .shcnt  (r_shcnt),
    .sign   (r_sign),
    .dbl    (r_dbl),
    .result (w_rnd_result),
    .nx     (w_rnd_nx)
  );

  assign req_ready  = (r_state == ST_IDLE);
  assign resp_valid = (r_state == ST_DONE);
  assign resp_data  = r_resp_data;
  assign resp_nx    = r_resp_nx;

endmodule : fcvt_int2fp_seq
`default_nettype wire

// File: tb/tb_fcvt_int2fp_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_fcvt_int2fp_seq                                            |
// | Description : Scoreboard bench for the integer to FP conversion sequencer   |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module tb_fcvt_int2fp_seq;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_op;
  logic        req_word;
  logic        req_signed;
  logic        req_dbl;
  logic        kill;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_data;
  logic        resp_nx;

  typedef struct {
    logic [63:0] data;
    logic        nx;
    int          lat;
    int          t0;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   n_resp = 0;
  bit   seen   = 1'b0;

  fcvt_int2fp_seq u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_word   (req_word),
    .req_signed (req_signed),
    .req_dbl    (req_dbl),
    .kill       (kill),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_nx    (resp_nx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected latency from leading-zero count: byte shifts, bit shifts, fixed overhead.
  function automatic int lat_of(input logic [63:0] m);
    int msb;
    int lz;
    msb = 0;
    if (m == 64'd0) return 2;
    for (int i = 0; i < 64; i++) if (m[i]) msb = i;
    lz = 63 - msb;
    return 3 + lz / 8 + lz % 8;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (resp_valid && !seen) begin
      seen = 1'b1;
      if (sb.size() > 0) chk_val("latency", 64'(cyc - sb[0].t0), 64'(sb[0].lat));
    end
    if (resp_valid && resp_ready) begin
      if (sb.size() == 0) begin
        chk_val("unexpected_resp", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        chk_val("resp_data", resp_data, e.data);
        chk_val("resp_nx", {63'd0, resp_nx}, {63'd0, e.nx});
      end
      seen = 1'b0;
      n_resp++;
    end
  end

  task automatic launch(input logic [63:0] op, input logic word, input logic sgn,
                        input logic dbl, input logic [63:0] exp_d, input logic exp_nx,
                        input logic [63:0] mag);
    exp_t e;
    int   k;
    k = 0;
    while (!req_ready && k < 100) begin tick(); k++; end
    if (!req_ready) chk_val("ready_timeout", 64'd0, 64'd1);
    req_op     = op;
    req_word   = word;
    req_signed = sgn;
    req_dbl    = dbl;
    req_valid  = 1'b1;
    e.data = exp_d;
    e.nx   = exp_nx;
    e.lat  = lat_of(mag);
    e.t0   = cyc;
    sb.push_back(e);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_resp(input int n0);
    int k;
    k = 0;
    while (n_resp == n0 && k < 100) begin tick(); k++; end
    if (n_resp == n0) chk_val("resp_timeout", 64'd0, 64'd1);
  endtask

  task automatic run_op(input logic [63:0] op, input logic word, input logic sgn,
                        input logic dbl, input logic [63:0] exp_d, input logic exp_nx,
                        input logic [63:0] mag);
    int n0;
    n0 = n_resp;
    launch(op, word, sgn, dbl, exp_d, exp_nx, mag);
    wait_resp(n0);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n0;
    int  k;
    bit  any_valid;
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_op     = 64'd0;
    req_word   = 1'b0;
    req_signed = 1'b0;
    req_dbl    = 1'b0;
    kill       = 1'b0;
    resp_ready = 1'b1;
    repeat (3) tick();
    chk_val("rst_req_ready", {63'd0, req_ready}, 64'd1);
    chk_val("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
    chk_val("rst_resp_data", resp_data, 64'd0);
    chk_val("rst_resp_nx", {63'd0, resp_nx}, 64'd0);
    rst_n = 1'b1;
    tick();

    run_op(64'd1, 1'b0, 1'b1, 1'b1, 64'h3FF0_0000_0000_0000, 1'b0, 64'd1);
    run_op(64'hDEAD_BEEF_FFFF_FFFF, 1'b1, 1'b1, 1'b0, 64'hFFFF_FFFF_BF80_0000, 1'b0, 64'd1);
    run_op(64'd0, 1'b0, 1'b1, 1'b1, 64'h0, 1'b0, 64'd0);
    run_op(64'd0, 1'b1, 1'b0, 1'b0, 64'hFFFF_FFFF_0000_0000, 1'b0, 64'd0);
    run_op(64'h0000_0000_0100_0003, 1'b0, 1'b0, 1'b0, 64'hFFFF_FFFF_4B80_0002, 1'b1,
           64'h0000_0000_0100_0003);
    run_op(64'h0020_0000_0000_0001, 1'b0, 1'b0, 1'b1, 64'h4340_0000_0000_0000, 1'b1,
           64'h0020_0000_0000_0001);
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b1, 64'h43F0_0000_0000_0000, 1'b1,
           64'hFFFF_FFFF_FFFF_FFFF);
    run_op(64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b1, 64'hC3E0_0000_0000_0000, 1'b0,
           64'h8000_0000_0000_0000);
    run_op(64'h1234_5678_8000_0000, 1'b1, 1'b0, 1'b0, 64'hFFFF_FFFF_4F00_0000, 1'b0,
           64'h0000_0000_8000_0000);
    run_op(64'hFFFF_0000_7FFF_FFFF, 1'b1, 1'b1, 1'b0, 64'hFFFF_FFFF_4F00_0000, 1'b1,
           64'h0000_0000_7FFF_FFFF);
    run_op(64'hFFFF_FFFF_FFFF_FFFB, 1'b0, 1'b1, 1'b1, 64'hC014_0000_0000_0000, 1'b0,
           64'd5);

    // Back-pressure: result must hold while the consumer stalls.
    resp_ready = 1'b0;
    n0 = n_resp;
    launch(64'd5, 1'b0, 1'b0, 1'b1, 64'h4014_0000_0000_0000, 1'b0, 64'd5);
    k = 0;
    while (!resp_valid && k < 100) begin tick(); k++; end
    chk_val("stall_valid_seen", {63'd0, resp_valid}, 64'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_val("stall_data", resp_data, 64'h4014_0000_0000_0000);
      chk_val("stall_req_ready", {63'd0, req_ready}, 64'd0);
    end
    resp_ready = 1'b1;
    wait_resp(n0);
    tick();

    // Flush in the middle of normalization.
    req_op = 64'd1; req_word = 1'b0; req_signed = 1'b0; req_dbl = 1'b1;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    repeat (3) tick();
    chk_val("norm_busy", {63'd0, req_ready}, 64'd0);
    kill = 1'b1;
    tick();
    kill = 1'b0;
    chk_val("kill_idle", {63'd0, req_ready}, 64'd1);
    any_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (resp_valid) any_valid = 1'b1;
      tick();
    end
    chk_val("kill_no_resp", {63'd0, any_valid}, 64'd0);

    // Flush coincident with a request in IDLE rejects it.
    req_op = 64'd7; req_valid = 1'b1; kill = 1'b1;
    tick();
    req_valid = 1'b0; kill = 1'b0;
    chk_val("kill_reject", {63'd0, req_ready}, 64'd1);

    // Asynchronous reset mid-operation.
    req_op = 64'd1; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    chk_val("arst_req_ready", {63'd0, req_ready}, 64'd1);
    chk_val("arst_resp_data", resp_data, 64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    run_op(64'h0000_0000_0000_0003, 1'b1, 1'b1, 1'b0, 64'hFFFF_FFFF_4040_0000, 1'b0, 64'd3);

    chk_val("sb_empty", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_fcvt_int2fp_seq
`default_nettype wire

// File: doc/fcvt_int2fp_seq.md
# fcvt_int2fp_seq

Multi-cycle sequencer for integer-to-floating-point conversion (RISC-V FCVT.S/D.W/WU/L/LU) inside the FPU. It accepts one request over a valid/ready handshake and derives the magnitude. It normalizes with an iterative shifter FSM instead of a single-cycle leading-one detector, then rounds to nearest-even and returns a NaN-boxed result with an inexact flag. It sits between the FPU issue stage and the FP register-file writeback.

## Interface
- `BUS_WIDTH`, 64, integer source / result register width (fixed at 64)
- `BIAS_D`, 1023, double exponent bias
- `BIAS_S`, 127, single exponent bias

- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `req_valid`  in  1  request present
- `req_ready`  out  1  block can accept a request
- `req_op`  in  64  integer operand
- `req_word`  in  1  1 = 32-bit source `req_op[31:0]`, 0 = 64-bit
- `req_signed`  in  1  1 = two's-complement source
- `req_dbl`  in  1  1 = double result, 0 = single
- `kill`  in  1  pipeline flush; abort current operation
- `resp_valid`  out  1  result present
- `resp_ready`  in  1  consumer takes result
- `resp_data`  out  64  result; for singles, `[63:32]` = all ones (NaN-box)
- `resp_nx`  out  1  inexact flag

## Operation
- States: IDLE, NORM, ROUND, DONE.
- **IDLE**
  - `req_ready` = 1.
  - On `req_valid`:
    - Latch `req_dbl`.
    - Sign-extend or zero-extend the operand to 64 bits.
    - `sign` = `req_signed` & bit 63 of the extended value.
    - `mag` = `sign` ? −value : value, unsigned 64-bit, so −2^63 gives 0x8000_0000_0000_0000.
    - `shcnt` = 0.
  - Next state: ROUND if `mag` == 0, else NORM.
- **NORM**, one step per cycle:
  - If `mag[63:56]` == 0: shift `mag` left 8, `shcnt` += 8.
  - Else if `mag[63]` == 0: shift left 1, `shcnt` += 1.
  - Else: go to ROUND.
  - `shcnt` is 6 bits and never exceeds 63.
- **ROUND**, combinational in `fcvt_round`, registered at the end of the cycle:
  - Double: `M` = `mag[62:11]`, `G` = `mag[10]`, `St` = |`mag[9:0]`.
  - Single: `M` = `mag[62:40]`, `G` = `mag[39]`, `St` = |`mag[38:0]`.
  - Round up when `G` & (`St` | `M[0]`).
  - Exponent = (63 − `shcnt`) + bias, computed 11 bits wide.
  - Mantissa carry-out: exponent + 1, mantissa field = 0.
  - Overflow to infinity cannot occur.
  - `resp_nx` = `G` | `St`.
  - Zero input gives +0 (single: 0xFFFFFFFF_00000000) with `nx` = 0.
  - Next state: DONE.
- **DONE**
  - `resp_valid` = 1; `resp_data` and `resp_nx` are held stable until `resp_ready`.
  - `resp_valid` & `resp_ready` → IDLE.
  - `req_ready` = 0, so there is no same-cycle re-accept.
- **kill** has priority over every transition:
  - Next state is IDLE and any pending result is dropped; `resp_valid` falls the next cycle.
  - `kill` in IDLE together with `req_valid` rejects the request.
- Reset mid-operation: immediate return to IDLE; all outputs go to their reset values.

## Timing
- Reset values: state IDLE, `req_ready` 1, `resp_valid` 0, `resp_data` 0, `resp_nx` 0.
- Accept in cycle T.
  - Operand with MSB already set: NORM at T+1, ROUND at T+2, `resp_valid` at T+3.
  - Each extra NORM step adds one cycle.
  - Worst case is `mag` = 1: 7 byte-shifts + 7 bit-shifts + 1 exit cycle gives `resp_valid` at T+17.
  - Zero operand: `resp_valid` at T+2.
- Throughput: one op in flight. Next accept is no earlier than the cycle after the response handshake.
- Outputs are registered; there is no combinational path from `req_*` to `resp_*`.

## Structure
- Shared package `fpu_pkg`:
  - `BIAS_D`, `BIAS_S`, mantissa/exponent widths for S and D.
  - The FSM state enum.
  - NaN-box constant 32'hFFFF_FFFF.
- Sub-module `fcvt_round` (combinational):
  - Inputs: normalized `mag`, `shcnt`, `sign`, `dbl`.
  - Outputs: packed result and `nx`.
- Top module holds the FSM, operand registers and handshake.

## Test plan
- Signed 64-bit 1, dbl → `resp_data` 0x3FF0000000000000, `nx` 0, `resp_valid` at T+17.
- Signed 32-bit 0xFFFFFFFF (−1), single → 0xFFFFFFFF_BF800000, `nx` 0.
- 0, any format → 0x0000000000000000 (dbl), `nx` 0, `resp_valid` at T+2.
- Unsigned 64-bit 2^24+3, single → 0xFFFFFFFF_4B800002, `nx` 1 (tie, odd LSB rounds up).
- Unsigned 2^53+1, dbl → 0x4340000000000000, `nx` 1 (tie, even LSB stays).
- Unsigned 0xFFFFFFFFFFFFFFFF, dbl → 0x43F0000000000000 via carry-out, `nx` 1.
- Hold `resp_ready` = 0 for 5 cycles → data stable, `req_ready` stays 0.
- Assert `kill` during NORM → IDLE next cycle, no `resp_valid`.
